ma_channel_scheduler: RTL and testbench



---
 rtl/ma_channel_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_ma_channel_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ma_channel_scheduler
// Purpose  : Shares one moving-average accumulate datapath across NUM_CH
//            independent sample streams. A round-robin arbiter grants one
//            requester at a time. A three-state sequencer (IDLE, UPDATE,
//            OUTPUT) updates that channel's running sum against its own
//            history ring, then presents the window average downstream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   flush       synchronous clear of all channel state
//   req_valid   per-channel sample valid
//   req_data    channel i sample on bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   per-channel accept (one-hot or zero, IDLE only)
//   out_valid   averaged result valid
//   out_ready   downstream accept
//   out_data    window average (sum >> log2(FILTER_LENGTH), truncating)
//   out_ch      channel that produced out_data
//   out_primed  channel had >= FILTER_LENGTH samples since reset/flush
//   busy        sequencer not in IDLE
// ============================================================================
module ma_channel_scheduler #(
   parameter int NUM_CH        = 4,
   parameter int FILTER_LENGTH = 16,
   parameter int DATA_WIDTH    = 16
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           flush,
   input  logic [NUM_CH-1:0]              req_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_CH-1:0]              req_ready,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic [$clog2(NUM_CH)-1:0]      out_ch,
   output logic                           out_primed,
   output logic                           busy
);

   localparam int CH_W   = $clog2(NUM_CH);
   localparam int PTR_W  = $clog2(FILTER_LENGTH);
   // Sum of FILTER_LENGTH samples needs PTR_W extra bits and can never wrap.
   localparam int SUM_W  = DATA_WIDTH + PTR_W;
   // Fill counter must be able to hold FILTER_LENGTH itself.
   localparam int FILL_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   state_t                  state;
   logic [CH_W-1:0]         rr;
   logic [CH_W-1:0]         cur_ch;
   logic [DATA_WIDTH-1:0]   cur_din;

   // -------------------------------------------------------------------------
   // Round-robin arbiter: first valid channel searching upward from rr+1.
   // -------------------------------------------------------------------------
   logic                    grant_found;
   logic [CH_W-1:0]         grant_ch;
   logic [CH_W-1:0]         cand;
   logic                    accept;

   always_comb begin
      grant_found = 1'b0;
      grant_ch    = '0;
      cand        = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = CH_W'((int'(rr) + i) % NUM_CH);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_ch    = cand;
         end
      end
   end

   // Accept only in IDLE, never during flush, and never while reset is held,
   // so a sample can't be handshaken into a state that is being cleared.
   assign accept    = reset_n && !flush && (state == IDLE) && grant_found;
   assign req_ready = accept ? (NUM_CH'(1) << grant_ch) : '0;
   assign busy      = (state != IDLE);

   // -------------------------------------------------------------------------
   // Per-channel state. Each channel only changes when it is the one being
   // updated, so channels never interact.
   // -------------------------------------------------------------------------
   logic                       upd_en;
   logic [NUM_CH*SUM_W-1:0]      ch_sum_flat;
   logic [NUM_CH*DATA_WIDTH-1:0] ch_old_flat;
   logic [NUM_CH*FILL_W-1:0]     ch_fill_flat;
   logic [SUM_W-1:0]           sel_sum;
   logic [DATA_WIDTH-1:0]      sel_old;
   logic [FILL_W-1:0]          sel_fill;
   logic [SUM_W-1:0]           sum_new;
   logic                       primed_next;

   assign upd_en = (state == UPDATE);

   genvar c;
   generate
      for (c = 0; c < NUM_CH; c++) begin : g_ch
         logic [DATA_WIDTH-1:0] hist [FILTER_LENGTH];
         logic [PTR_W-1:0]      wp;
         logic [SUM_W-1:0]      sum;
         logic [FILL_W-1:0]     fill;
         logic                  hit;

         assign hit = upd_en && (cur_ch == CH_W'(c));

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int k = 0; k < FILTER_LENGTH; k++) begin
                  hist[k] <= '0;
               end
               wp   <= '0;
               sum  <= '0;
               fill <= '0;
            end else if (flush) begin
               for (int k = 0; k < FILTER_LENGTH; k++) begin
                  hist[k] <= '0;
               end
               wp   <= '0;
               sum  <= '0;
               fill <= '0;
            end else if (hit) begin
               hist[wp] <= cur_din;
               // FILTER_LENGTH is a power of two, so the pointer wraps for free.
               wp       <= wp + PTR_W'(1);
               sum      <= sum_new;
               if (fill != FILL_W'(FILTER_LENGTH)) begin
                  fill <= fill + FILL_W'(1);
               end
            end
         end

         // Unwritten slots are still zero, so the ramp-up average falls out
         // of the same add/subtract without a special case.
         assign ch_sum_flat[c*SUM_W +: SUM_W]           = sum;
         assign ch_old_flat[c*DATA_WIDTH +: DATA_WIDTH] = hist[wp];
         assign ch_fill_flat[c*FILL_W +: FILL_W]        = fill;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Shared accumulate datapath for the channel being updated.
   // -------------------------------------------------------------------------
   assign sel_sum  = ch_sum_flat[cur_ch*SUM_W +: SUM_W];
   assign sel_old  = ch_old_flat[cur_ch*DATA_WIDTH +: DATA_WIDTH];
   assign sel_fill = ch_fill_flat[cur_ch*FILL_W +: FILL_W];

   // The oldest sample is always part of the current sum, so no underflow.
   assign sum_new     = sel_sum + SUM_W'(cur_din) - SUM_W'(sel_old);
   // fill+1 >= FILTER_LENGTH, written without the increment to avoid overflow.
   assign primed_next = (sel_fill >= FILL_W'(FILTER_LENGTH - 1));

   // -------------------------------------------------------------------------
   // Sequencer with registered result outputs.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         rr         <= CH_W'(NUM_CH - 1);
         cur_ch     <= '0;
         cur_din    <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_ch     <= '0;
         out_primed <= 1'b0;
      end else if (flush) begin
         // Any in-flight result is dropped; out_data/out_ch keep their value.
         state      <= IDLE;
         rr         <= CH_W'(NUM_CH - 1);
         out_valid  <= 1'b0;
         out_primed <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cur_ch  <= grant_ch;
                  cur_din <= req_data[grant_ch*DATA_WIDTH +: DATA_WIDTH];
                  rr      <= grant_ch;
                  state   <= UPDATE;
               end
            end
            UPDATE: begin
               out_data   <= DATA_WIDTH'(sum_new >> PTR_W);
               out_ch     <= cur_ch;
               out_primed <= primed_next;
               out_valid  <= 1'b1;
               state      <= OUTPUT;
            end
            OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ma_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ma_channel_scheduler
// Purpose  : Self-checking bench for ma_channel_scheduler (4 channels,
//            window of 4, 16-bit samples). A transaction-level model keeps a
//            queue of recent samples per channel and predicts grants and
//            results; table vectors and hand sequences cover the corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ma_channel_scheduler;

   localparam int NC = 4;
   localparam int FL = 4;
   localparam int DW = 16;
   localparam int CW = 2;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              flush;
   logic [NC-1:0]     req_valid;
   logic [NC*DW-1:0]  req_data;
   logic [NC-1:0]     req_ready;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic [CW-1:0]     out_ch;
   logic              out_primed;
   logic              busy;

   always #5 clk = ~clk;

   ma_channel_scheduler #(
      .NUM_CH       (NC),
      .FILTER_LENGTH(FL),
      .DATA_WIDTH   (DW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_primed(out_primed),
      .busy      (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   int win [NC][$];
   int nsamp [NC];
   int m_rr;
   bit m_idle, m_lat, m_ov, m_op, p_p;
   int m_od, m_och, p_d, p_ch;

   function automatic int exp_grant(input logic [NC-1:0] v, input int rr);
      for (int i = 1; i <= NC; i++) begin
         if (v[(rr + i) % NC]) return (rr + i) % NC;
      end
      return -1;
   endfunction

   task automatic model_flush();
      for (int k = 0; k < NC; k++) begin
         win[k].delete();
         nsamp[k] = 0;
      end
      m_rr = NC - 1; m_idle = 1; m_lat = 0; m_ov = 0; m_op = 0;
   endtask

   task automatic model_reset();
      model_flush();
      m_od = 0; m_och = 0;
   endtask

   task automatic model_edge();
      int g, s;
      if (flush) begin model_flush(); return; end
      if (m_ov) begin
         if (out_ready) begin m_ov = 0; m_idle = 1; end
         return;
      end
      if (m_lat) begin
         m_lat = 0; m_ov = 1; m_od = p_d; m_och = p_ch; m_op = p_p;
         return;
      end
      if (m_idle && req_valid != '0) begin
         g = exp_grant(req_valid, m_rr);
         m_rr = g;
         win[g].push_back(int'(req_data[g*DW +: DW]));
         if (win[g].size() > FL) void'(win[g].pop_front());
         nsamp[g]++;
         s = 0;
         foreach (win[g][k]) s += win[g][k];
         p_d = s / FL; p_ch = g; p_p = (nsamp[g] >= FL);
         m_idle = 0; m_lat = 1;
      end
   endtask

   // ------------------------------------------------------ sampling / tick
   logic [NC-1:0] s_ready;
   logic          s_ov, s_op, s_busy;
   logic [DW-1:0] s_od;
   logic [CW-1:0] s_och;

   task automatic check_outputs();
      int g;
      logic [NC-1:0] er;
      s_ready = req_ready; s_ov = out_valid; s_od = out_data;
      s_och = out_ch; s_op = out_primed; s_busy = busy;
      er = '0;
      g = exp_grant(req_valid, m_rr);
      if (reset_n && !flush && m_idle && g >= 0) er[g] = 1'b1;
      chk("req_ready", s_ready, er);
      chk("out_valid", s_ov, m_ov);
      chk("out_data", s_od, m_od);
      chk("out_ch", s_och, m_och);
      chk("out_primed", s_op, m_op);
      chk("busy", s_busy, !m_idle);
   endtask

   // Inputs are set at posedge+1; outputs checked at posedge+2.
   task automatic tick();
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_ch(input int ch, input int val);
      req_data[ch*DW +: DW] = val[DW-1:0];
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic wait_grant(input int ch);
      int n = 0;
      do begin tick(); n++; end while (!s_ready[ch] && n < 50);
      if (!s_ready[ch]) begin
         checks++; errors++;
         $display("FAIL grant_timeout ch%0d", ch);
      end
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin tick(); lat++; end while (!s_ov && lat < 50);
      if (!s_ov) begin
         checks++; errors++;
         $display("FAIL out_valid_timeout");
      end
   endtask

   task automatic send_one(input int ch, input int data, output int lat,
                           output logic [DW-1:0] d, output logic p, output int och);
      req_valid = '0; req_valid[ch] = 1'b1; set_ch(ch, data); out_ready = 1'b1;
      wait_grant(ch);
      req_valid = '0;
      wait_out(lat);
      d = s_od; p = s_op; och = int'(s_och);
   endtask

   typedef struct {
      int ch;
      int data;
      int exp_data;
      bit exp_primed;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int lat, och, n, gcnt, idx;
      logic [DW-1:0] d, hold;
      logic p;
      int grants [6];
      int exp_order [6];

      tbl[0]  = '{0, 100, 25, 0};
      tbl[1]  = '{0, 200, 75, 0};
      tbl[2]  = '{0, 300, 150, 0};
      tbl[3]  = '{0, 400, 250, 1};
      tbl[4]  = '{0, 500, 350, 1};
      tbl[5]  = '{2, 16'hFFFF, 16'h3FFF, 0};
      tbl[6]  = '{2, 16'hFFFF, 16'h7FFF, 0};
      tbl[7]  = '{2, 16'hFFFF, 16'hBFFF, 0};
      tbl[8]  = '{2, 16'hFFFF, 16'hFFFF, 1};
      tbl[9]  = '{2, 16'hFFFF, 16'hFFFF, 1};
      tbl[10] = '{2, 16'hFFFF, 16'hFFFF, 1};
      exp_order = '{0, 1, 2, 3, 0, 1};

      // ------------------------------------------------------------ reset
      reset_n = 1'b0; flush = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset_n = 1'b1;

      // ------------------------------------------------------ table vectors
      for (int i = 0; i < 11; i++) begin
         send_one(tbl[i].ch, tbl[i].data, lat, d, p, och);
         chk("tbl_latency", lat, 2);
         chk("tbl_data", d, tbl[i].exp_data);
         chk("tbl_primed", p, tbl[i].exp_primed);
         chk("tbl_ch", och, tbl[i].ch);
      end

      // ------------------------------------- all channels valid, rr order
      do_flush();
      for (int k = 0; k < NC; k++) set_ch(k, 8 + 10 * k);
      req_valid = '1; out_ready = 1'b1;
      gcnt = 0; n = 0;
      while (gcnt < 6 && n < 100) begin
         tick(); n++;
         if (s_ready != '0) begin
            chk("ready_onehot", $onehot(s_ready), 1);
            idx = 0;
            for (int k = 0; k < NC; k++) if (s_ready[k]) idx = k;
            grants[gcnt] = idx;
            gcnt++;
         end
      end
      chk("grant_count", gcnt, 6);
      for (int k = 0; k < 6; k++) chk("grant_order", grants[k], exp_order[k]);
      req_valid = '0;
      wait_out(lat);

      // ---------------------------------------------- output backpressure
      tick();
      req_valid = '0; req_valid[1] = 1'b1; set_ch(1, 1234); out_ready = 1'b0;
      wait_grant(1);
      req_valid = '1;
      wait_out(lat);
      hold = s_od;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_valid", s_ov, 1);
         chk("bp_data", s_od, hold);
         chk("bp_ch", s_och, 1);
         chk("bp_ready", s_ready, 0);
      end
      req_valid = '0; out_ready = 1'b1;
      tick();
      tick();
      chk("bp_idle", s_busy, 0);

      // ----------------------------------------- flush during OUTPUT
      do_flush();
      for (int k = 0; k < 4; k++) send_one(0, 400, lat, d, p, och);
      for (int k = 0; k < 4; k++) send_one(3, 800, lat, d, p, och);
      req_valid = '0; req_valid[0] = 1'b1; set_ch(0, 400); out_ready = 1'b0;
      wait_grant(0);
      req_valid = '0;
      wait_out(lat);
      chk("pre_flush_primed", s_op, 1);
      chk("pre_flush_data", s_od, 400);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("flush_valid", s_ov, 0);
      chk("flush_primed", s_op, 0);
      send_one(0, 400, lat, d, p, och);
      chk("post_flush_ch0", d, 100);
      chk("post_flush_ch0_primed", p, 0);
      send_one(3, 400, lat, d, p, och);
      chk("post_flush_ch3", d, 100);
      chk("post_flush_ch3_primed", p, 0);

      // ----------------------------------------- async reset mid-UPDATE
      req_valid = '0; req_valid[2] = 1'b1; set_ch(2, 4000); out_ready = 1'b1;
      wait_grant(2);
      req_valid = '0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_out_primed", out_primed, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int k = 0; k < NC; k++) set_ch(k, 40 + k);
      req_valid = '1;
      tick();
      chk("rst_first_grant", s_ready, 4'b0001);
      req_valid = '0;
      wait_out(lat);
      chk("rst_restart_data", s_od, 10);
      chk("rst_restart_primed", s_op, 0);

      // ------------------------------------------------ random stimulus
      for (int cyc = 0; cyc < 600; cyc++) begin
         req_valid = NC'($urandom);
         for (int k = 0; k < NC; k++)
            set_ch(k, ($urandom_range(0, 3) == 0) ? 16'hFFFF : int'($urandom_range(0, 65535)));
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 59) == 0);
         tick();
      end
      flush = 1'b0;
      req_valid = '0;
      out_ready = 1'b1;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
